// File: rtl/cpu_control_unit.sv
// Multi-cycle fetch/decode/execute sequencer for the 8-bit RISC core (PC, IR, 4x8 regfile, zero flag).
// Optional CTRL_ILLEGAL_TRAP_EN: illegal opcodes halt the core and raise a sticky illegal output.
module cpu_control_unit #(
  parameter logic [7:0] RESET_PC = 8'h00
) (
  input  logic       clk,
  input  logic       rst_n,
  output logic       mem_req,
  output logic [7:0] mem_addr,
  input  logic [7:0] mem_rdata,
  input  logic       mem_ready,
  output logic [7:0] alu_a,
  output logic [7:0] alu_b,
  output logic [2:0] alu_sel,
  input  logic [7:0] alu_out,
  input  logic       alu_zero,
  output logic [7:0] pc,
  output logic       z_flag,
  output logic       halted
`ifdef CTRL_ILLEGAL_TRAP_EN
  ,
  output logic       illegal
`endif
);

  typedef enum logic [2:0] {
    S_FETCH, S_DECODE, S_FETCH_IMM, S_EXECUTE, S_WRITEBACK, S_HALT
  } state_t;

  localparam logic [3:0] OP_LDI  = 4'h5;
  localparam logic [3:0] OP_JMP  = 4'h6;
  localparam logic [3:0] OP_JZ   = 4'h7;
  localparam logic [3:0] OP_MOV  = 4'h8;
  localparam logic [3:0] OP_HALT = 4'hF;

  state_t     state, state_next;
  logic [7:0] ir, imm, res;
  logic       res_zero;
  logic [7:0] regs [4];
  logic [7:0] pc_next, reg_wdata;
  logic       ir_load, imm_load, res_load, reg_we, z_we;
  logic [3:0] opcode;
  logic [1:0] rd, rs;
  logic       is_alu;
`ifdef CTRL_ILLEGAL_TRAP_EN
  logic       illegal_set;
`endif

  assign opcode   = ir[7:4];
  assign rd       = ir[3:2];
  assign rs       = ir[1:0];
  assign is_alu   = (opcode <= 4'd4);
  assign alu_a    = regs[rd];
  assign alu_b    = regs[rs];
  assign mem_addr = pc;
  assign halted   = (state == S_HALT);
  // State resets to FETCH asynchronously, so the request must be gated by rst_n itself.
  assign mem_req  = rst_n && ((state == S_FETCH) || (state == S_FETCH_IMM));

  always_comb begin
    state_next = state;
    pc_next    = pc;
    ir_load    = 1'b0;
    imm_load   = 1'b0;
    res_load   = 1'b0;
    reg_we     = 1'b0;
    reg_wdata  = '0;
    z_we       = 1'b0;
    alu_sel    = 3'b111;
`ifdef CTRL_ILLEGAL_TRAP_EN
    illegal_set = 1'b0;
`endif
    case (state)
      S_FETCH: if (mem_ready) begin
        ir_load    = 1'b1;
        pc_next    = pc + 8'd1;
        state_next = S_DECODE;
      end
      S_DECODE: begin
        case (opcode)
          OP_LDI, OP_JMP, OP_JZ: state_next = S_FETCH_IMM;
          OP_MOV:                state_next = S_EXECUTE;
          OP_HALT:               state_next = S_HALT;
          default: begin
            if (is_alu) state_next = S_EXECUTE;
            else begin
`ifdef CTRL_ILLEGAL_TRAP_EN
              illegal_set = 1'b1;
              state_next  = S_HALT;
`else
              state_next  = S_FETCH;
`endif
            end
          end
        endcase
      end
      S_FETCH_IMM: if (mem_ready) begin
        imm_load   = 1'b1;
        pc_next    = pc + 8'd1;
        state_next = S_EXECUTE;
      end
      S_EXECUTE: begin
        if (is_alu) begin
          alu_sel    = opcode[2:0];
          res_load   = 1'b1;
          state_next = S_WRITEBACK;
        end else begin
          case (opcode)
            OP_JMP: begin
              pc_next    = imm;
              state_next = S_FETCH;
            end
            OP_JZ: begin
              if (z_flag) pc_next = imm;
              state_next = S_FETCH;
            end
            default: state_next = S_WRITEBACK;
          endcase
        end
      end
      S_WRITEBACK: begin
        reg_we     = 1'b1;
        state_next = S_FETCH;
        if (is_alu) begin
          reg_wdata = res;
          z_we      = 1'b1;
        end else if (opcode == OP_LDI) begin
          reg_wdata = imm;
        end else begin
          reg_wdata = regs[rs];
        end
      end
      S_HALT: state_next = S_HALT;
      default: state_next = S_FETCH;
    endcase
  end

  always_ff @(posedge clk or negedge rst_n) begin
    if (!rst_n) begin
      state    <= S_FETCH;
      pc       <= RESET_PC;
      ir       <= '0;
      imm      <= '0;
      res      <= '0;
      res_zero <= 1'b0;
      z_flag   <= 1'b0;
      for (int unsigned i = 0; i < 4; i++) regs[i] <= '0;
    end else begin
      state <= state_next;
      pc    <= pc_next;
      if (ir_load)  ir  <= mem_rdata;
      if (imm_load) imm <= mem_rdata;
      if (res_load) begin
        res      <= alu_out;
        res_zero <= alu_zero;
      end
      if (reg_we) regs[rd] <= reg_wdata;
      if (z_we)   z_flag   <= res_zero;
    end
  end

`ifdef CTRL_ILLEGAL_TRAP_EN
  always_ff @(posedge clk or negedge rst_n) begin
    if (!rst_n)           illegal <= 1'b0;
    else if (illegal_set) illegal <= 1'b1;
  end
`endif

endmodule
